// File: rtl/rsa_modexp_host.sv
// Host controller for the square-and-multiply RSA engine: loads m/e/n from a word stream,
// launches the engine and serialises the result. RSA_HOST_TIMEOUT_EN adds a WAIT watchdog.
module rsa_modexp_host #(
    parameter int unsigned BUS_WIDTH      = 2048,
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [WORD_WIDTH-1:0] in_data_i,
    input  logic [1:0]            in_sel_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  error_o,
    output logic [BUS_WIDTH-1:0]  eng_m_o,
    output logic [BUS_WIDTH-1:0]  eng_e_o,
    output logic [BUS_WIDTH-1:0]  eng_n_o,
    output logic                  eng_ready_o,
    input  logic [BUS_WIDTH-1:0]  eng_result_i,
    input  logic                  eng_valid_i,
    output logic [WORD_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o
);

    localparam int unsigned WORDS = BUS_WIDTH / WORD_WIDTH;
    localparam int unsigned CW    = $clog2(WORDS + 1);
    localparam logic [CW-1:0] WordsC   = CW'(WORDS);
    localparam logic [CW-1:0] LastIdxC = CW'(WORDS - 1);

    if (WORDS < 2 || BUS_WIDTH % WORD_WIDTH != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("rsa_modexp_host: BUS_WIDTH must be a multiple (>=2) of WORD_WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StStart, StWait, StDrain} state_e;

    state_e                state_q, state_d;
    logic [BUS_WIDTH-1:0]  opnd_q [3];
    logic [BUS_WIDTH-1:0]  opnd_d [3];
    logic [CW-1:0]         cnt_q  [3];
    logic [CW-1:0]         cnt_d  [3];
    logic [BUS_WIDTH-1:0]  res_q, res_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic                  prev_valid_q, prev_valid_d;
    logic                  error_q, error_d;
    logic                  sel_room;
    logic                  accept;
    logic                  all_full;
    logic                  timeout;

`ifdef RSA_HOST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimeoutLastC = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_q, timer_d;

    assign timer_d = (state_q == StWait) ? timer_q + TW'(1) : '0;
    assign timeout = (state_q == StWait) && (timer_q == TimeoutLastC);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        sel_room = 1'b1;
        all_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (in_sel_i == 2'(i)) begin
                sel_room = cnt_q[i] < WordsC;
            end
            if (cnt_q[i] != WordsC) begin
                all_full = 1'b0;
            end
        end
    end

    assign in_ready_o  = (state_q == StIdle) && sel_room;
    assign accept      = in_valid_i && in_ready_o;
    assign busy_o      = (state_q != StIdle);
    assign error_o     = error_q;
    assign eng_ready_o = (state_q == StStart);
    assign eng_m_o     = opnd_q[0];
    assign eng_e_o     = opnd_q[1];
    assign eng_n_o     = opnd_q[2];
    assign out_valid_o = (state_q == StDrain);
    assign out_data_o  = res_q[WORD_WIDTH-1:0];
    assign out_last_o  = (state_q == StDrain) && (idx_q == LastIdxC);

    // Operand shift registers: newest word enters at the top, so word 0 ends up lowest.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            opnd_d[i] = opnd_q[i];
            cnt_d[i]  = cnt_q[i];
            if (state_q == StStart) begin
                cnt_d[i] = '0;
            end else if (accept && in_sel_i == 2'(i)) begin
                opnd_d[i] = {in_data_i, opnd_q[i][BUS_WIDTH-1:WORD_WIDTH]};
                cnt_d[i]  = cnt_q[i] + CW'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        error_d      = 1'b0;
        res_d        = res_q;
        idx_d        = idx_q;
        prev_valid_d = prev_valid_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (!all_full || opnd_q[2] == '0) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                prev_valid_d = eng_valid_i;
                // Only a fresh rising edge counts; a level left over from a prior run is ignored.
                if (eng_valid_i && !prev_valid_q) begin
                    res_d   = eng_result_i;
                    idx_d   = '0;
                    state_d = StDrain;
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (out_ready_i) begin
                    res_d = res_q >> WORD_WIDTH;
                    idx_d = idx_q + CW'(1);
                    if (idx_q == LastIdxC) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            res_q        <= '0;
            idx_q        <= '0;
            prev_valid_q <= 1'b0;
            error_q      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                opnd_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            idx_q        <= idx_d;
            prev_valid_q <= prev_valid_d;
            error_q      <= error_d;
            for (int i = 0; i < 3; i++) begin
                opnd_q[i] <= opnd_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rsa_modexp_host.sv
// Directed self-checking bench for rsa_modexp_host with BUS_WIDTH=64, WORD_WIDTH=32.
module tb_rsa_modexp_host;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        busy;
    logic        error;
    logic [63:0] eng_m, eng_e, eng_n;
    logic        eng_ready;
    logic [63:0] eng_result;
    logic        eng_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int tests_run = 0;
    int fails     = 0;

    rsa_modexp_host #(
        .BUS_WIDTH      (64),
        .WORD_WIDTH     (32),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .in_data_i    (in_data),
        .in_sel_i     (in_sel),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .start_i      (start),
        .busy_o       (busy),
        .error_o      (error),
        .eng_m_o      (eng_m),
        .eng_e_o      (eng_e),
        .eng_n_o      (eng_n),
        .eng_ready_o  (eng_ready),
        .eng_result_i (eng_result),
        .eng_valid_i  (eng_valid),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_last_o   (out_last)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load64(input logic [1:0] sel, input logic [63:0] v);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = v[31:0];
        step();
        in_data  = v[63:32];
        step();
        in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        step();
        reset    = 1'b0;
    endtask

    // Loads all operands and starts; returns with the DUT in its first WAIT cycle.
    task automatic launch(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n);
        load64(2'd0, m);
        load64(2'd1, e);
        load64(2'd2, n);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0;
        eng_result = '0; eng_valid = 1'b0; out_ready = 1'b0;
        step();
        tests_run++;
        if ({busy, error, eng_ready, out_valid, out_last} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl got %b want 00000",
                              {busy, error, eng_ready, out_valid, out_last});
        end
        tests_run++;
        if ((eng_m | eng_e | eng_n) !== 64'd0 || out_data !== 32'd0) begin
            fails++; $display("FAIL reset_data got m=%0h e=%0h n=%0h out=%0h want 0",
                              eng_m, eng_e, eng_n, out_data);
        end
        reset = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    // 4^13 mod 497 = 445
    task automatic test_basic();
        load64(2'd0, 64'd4);
        load64(2'd1, 64'd13);
        load64(2'd2, 64'd497);
        tests_run++;
        if (eng_m !== 64'd4 || eng_e !== 64'd13 || eng_n !== 64'd497) begin
            fails++; $display("FAIL basic_operands got m=%0d e=%0d n=%0d want 4 13 497",
                              eng_m, eng_e, eng_n);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if (eng_ready !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin
            fails++; $display("FAIL basic_launch got rdy=%b busy=%b err=%b want 1 1 0",
                              eng_ready, busy, error);
        end
        step();
        tests_run++;
        if (eng_ready !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL basic_one_pulse got rdy=%b in_ready=%b want 0 0",
                              eng_ready, in_ready);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL basic_wait_quiet got out_valid=%b want 0", out_valid);
        end
        eng_result = 64'd445; eng_valid = 1'b1; out_ready = 1'b1;
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'd445 || out_last !== 1'b0) begin
            fails++; $display("FAIL basic_word0 got v=%b d=%0d l=%b want 1 445 0",
                              out_valid, out_data, out_last);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'd0 || out_last !== 1'b1) begin
            fails++; $display("FAIL basic_word1 got v=%b d=%0d l=%b want 1 0 1",
                              out_valid, out_data, out_last);
        end
        step();
        eng_valid = 1'b0;
        in_sel = 2'd2;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL basic_done got busy=%b v=%b in_ready=%b want 0 0 1",
                              busy, out_valid, in_ready);
        end
    endtask

    task automatic test_missing_operand();
        load64(2'd0, 64'd4);
        load64(2'd1, 64'd13);
        in_sel = 2'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if (error !== 1'b1 || eng_ready !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL missing_reject got err=%b rdy=%b busy=%b in_ready=%b want 1 0 0 1",
                              error, eng_ready, busy, in_ready);
        end
        step();
        tests_run++;
        if (error !== 1'b0 || eng_ready !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL missing_pulse got err=%b rdy=%b busy=%b want 0 0 0",
                              error, eng_ready, busy);
        end
    endtask

    task automatic test_zero_modulus();
        load64(2'd2, 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if (error !== 1'b1 || eng_ready !== 1'b0) begin
            fails++; $display("FAIL zero_n_reject got err=%b rdy=%b want 1 0", error, eng_ready);
        end
        step();
        tests_run++;
        if (busy !== 1'b0 || eng_ready !== 1'b0 || error !== 1'b0) begin
            fails++; $display("FAIL zero_n_idle got busy=%b rdy=%b err=%b want 0 0 0",
                              busy, eng_ready, error);
        end
        in_sel = 2'd2;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL full_stall_n got in_ready=%b want 0", in_ready);
        end
        in_sel = 2'd3;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL discard_ready got in_ready=%b want 1", in_ready);
        end
        apply_reset();
    endtask

    // Start in the same cycle as the last n word sees the pre-update count.
    task automatic test_same_cycle_start();
        load64(2'd0, 64'd4);
        load64(2'd1, 64'd13);
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'd497;
        step();
        in_data = 32'd0; start = 1'b1;
        step();
        in_valid = 1'b0; start = 1'b0;
        tests_run++;
        if (error !== 1'b1 || eng_ready !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL same_cycle_reject got err=%b rdy=%b busy=%b want 1 0 0",
                              error, eng_ready, busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if (eng_ready !== 1'b1 || eng_n !== 64'd497) begin
            fails++; $display("FAIL same_cycle_launch got rdy=%b n=%0d want 1 497", eng_ready, eng_n);
        end
        apply_reset();
    endtask

    task automatic test_backpressure();
        launch(64'd4, 64'd13, 64'd497);
        out_ready = 1'b0; eng_result = 64'd445; eng_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 32'd445 || out_last !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d got v=%b d=%0d l=%b want 1 445 0",
                                  i, out_valid, out_data, out_last);
            end
            step();
        end
        out_ready = 1'b1;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'd445) begin
            fails++; $display("FAIL bp_word0 got v=%b d=%0d want 1 445", out_valid, out_data);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'd0 || out_last !== 1'b1) begin
            fails++; $display("FAIL bp_word1 got v=%b d=%0d l=%b want 1 0 1",
                              out_valid, out_data, out_last);
        end
        step();
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_done got busy=%b v=%b want 0 0", busy, out_valid);
        end
    endtask

    // eng_valid is still high from the previous run; only a new edge may capture.
    // (2^32)^1 mod (2^64-1) = 2^32 -> words 0 then 1.
    task automatic test_back_to_back();
        launch(64'h0000_0001_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        tests_run++;
        if (eng_m !== 64'h0000_0001_0000_0000) begin
            fails++; $display("FAIL b2b_word_order got m=%h want 0000000100000000", eng_m);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                fails++; $display("FAIL b2b_stale_level%0d got v=%b busy=%b want 0 1",
                                  i, out_valid, busy);
            end
        end
        eng_valid = 1'b0;
        step();
        eng_result = 64'h0000_0001_0000_0000; eng_valid = 1'b1; out_ready = 1'b1;
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'd0 || out_last !== 1'b0) begin
            fails++; $display("FAIL b2b_word0 got v=%b d=%0d l=%b want 1 0 0",
                              out_valid, out_data, out_last);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'd1 || out_last !== 1'b1) begin
            fails++; $display("FAIL b2b_word1 got v=%b d=%0d l=%b want 1 1 1",
                              out_valid, out_data, out_last);
        end
        step();
        eng_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL b2b_done got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_in_wait();
        launch(64'd4, 64'd13, 64'd497);
        tests_run++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL rst_wait_entry got busy=%b want 1", busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_sel = 2'd0;
        tests_run++;
        if ({busy, error, eng_ready, out_valid, out_last} !== 5'b0 ||
            (eng_m | eng_e | eng_n) !== 64'd0) begin
            fails++; $display("FAIL rst_wait_outputs got ctrl=%b ops=%0h want 0 0",
                              {busy, error, eng_ready, out_valid, out_last}, eng_m | eng_e | eng_n);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL rst_wait_counts got in_ready=%b want 1", in_ready);
        end
        eng_result = 64'd445; eng_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                fails++; $display("FAIL rst_wait_no_out%0d got v=%b busy=%b want 0 0",
                                  i, out_valid, busy);
            end
        end
        eng_valid = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        launch(64'd4, 64'd13, 64'd497);
`ifdef RSA_HOST_TIMEOUT_EN
        for (int i = 1; i < 20; i++) begin
            step();
            tests_run++;
            if (busy !== 1'b1 || error !== 1'b0) begin
                fails++; $display("FAIL to_early%0d got busy=%b err=%b want 1 0", i, busy, error);
            end
        end
        step();
        tests_run++;
        if (error !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL to_fire got err=%b busy=%b v=%b want 1 0 0",
                              error, busy, out_valid);
        end
        step();
        tests_run++;
        if (error !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL to_pulse got err=%b v=%b want 0 0", error, out_valid);
        end
`else
        for (int i = 1; i < 40; i++) begin
            step();
            tests_run++;
            if (busy !== 1'b1 || error !== 1'b0) begin
                fails++; $display("FAIL wait_forever%0d got busy=%b err=%b want 1 0",
                                  i, busy, error);
            end
        end
        apply_reset();
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_missing_operand();
        test_zero_modulus();
        test_same_cycle_start();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
